// File: rtl/trade_executor.sv
// Closed-loop trade executor: packs price history plus ownership into frames for the
// day_trading generator, then applies the returned action code to a saturating position.
module trade_executor #(
   parameter int unsigned POS_MAX = 255,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        price_valid,
   input  logic [4:0]  price_in,
   output logic [15:0] stock_out,
   output logic        stock_valid,
   input  logic [15:0] action_in,
   input  logic        action_valid,
   output logic [7:0]  position,
   output logic        owned,
   output logic [15:0] trade_count,
   output logic        timeout,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ISSUE = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  old_q, old_d, mid_q, mid_d, new_q, new_d;
   logic [1:0]  fill_q, fill_d;
   logic        pending_q, pending_d;
   logic [7:0]  wait_q, wait_d;
   logic [15:0] stock_out_q, stock_out_d;
   logic        stock_valid_q, stock_valid_d;
   logic [7:0]  position_q, position_d;
   logic [15:0] trade_count_q, trade_count_d;
   logic        timeout_q, timeout_d;
   logic        err_q, err_d;

   logic        owned_w;
   logic        pend_w;
   logic        code_ok;
   logic [3:0]  add_amt;
   logic [8:0]  sum;

   assign owned_w = (position_q != 8'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         old_q         <= '0;
         mid_q         <= '0;
         new_q         <= '0;
         fill_q        <= '0;
         pending_q     <= 1'b0;
         wait_q        <= '0;
         stock_out_q   <= '0;
         stock_valid_q <= 1'b0;
         position_q    <= '0;
         trade_count_q <= '0;
         timeout_q     <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         old_q         <= old_d;
         mid_q         <= mid_d;
         new_q         <= new_d;
         fill_q        <= fill_d;
         pending_q     <= pending_d;
         wait_q        <= wait_d;
         stock_out_q   <= stock_out_d;
         stock_valid_q <= stock_valid_d;
         position_q    <= position_d;
         trade_count_q <= trade_count_d;
         timeout_q     <= timeout_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      old_d         = old_q;
      mid_d         = mid_q;
      new_d         = new_q;
      fill_d        = fill_q;
      pending_d     = pending_q;
      wait_d        = wait_q;
      stock_out_d   = stock_out_q;
      stock_valid_d = 1'b0;
      position_d    = position_q;
      trade_count_d = trade_count_q;
      timeout_d     = 1'b0;
      err_d         = err_q;
      pend_w        = pending_q;
      code_ok       = 1'b1;
      add_amt       = 4'd0;
      sum           = 9'd0;

      // Samples are never refused; the history always tracks the feed.
      if (price_valid) begin
         old_d = mid_q;
         mid_d = new_q;
         new_d = price_in;
         if (fill_q != 2'd3) fill_d = fill_q + 2'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (price_valid && fill_d == 2'd3) begin
               stock_out_d   = {owned_w, old_d, mid_d, new_d};
               stock_valid_d = 1'b1;
               wait_d        = 8'd0;
               state_d       = S_WAIT;
            end
         end
         S_WAIT: begin
            pend_w    = pending_q | price_valid;
            pending_d = pend_w;
            wait_d    = wait_q + 8'd1;
            if (action_valid) begin
               case (action_in)
                  16'd1:   position_d = 8'd0;
                  16'd2:   add_amt = 4'd0;
                  16'd3:   add_amt = 4'd4;
                  16'd4:   add_amt = 4'd8;
                  16'd5:   position_d = position_q >> 1;
                  16'd6:   add_amt = 4'd2;
                  16'd7:   add_amt = 4'd1;
                  16'd8:   add_amt = 4'd0;
                  default: code_ok = 1'b0;
               endcase
               if (code_ok) begin
                  trade_count_d = trade_count_q + 16'd1;
                  if (add_amt != 4'd0) begin
                     sum = {1'b0, position_q} + {5'd0, add_amt};
                     position_d = (sum > 9'(POS_MAX)) ? 8'(POS_MAX) : sum[7:0];
                  end
               end else begin
                  err_d = 1'b1;
               end
               state_d = pend_w ? S_ISSUE : S_IDLE;
            end else if (wait_q == 8'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = pend_w ? S_ISSUE : S_IDLE;
            end
         end
         S_ISSUE: begin
            // owned here already reflects the action that ended the previous frame.
            stock_out_d   = {owned_w, old_d, mid_d, new_d};
            stock_valid_d = 1'b1;
            pending_d     = 1'b0;
            wait_d        = 8'd0;
            state_d       = S_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stock_out   = stock_out_q;
   assign stock_valid = stock_valid_q;
   assign position    = position_q;
   assign owned       = owned_w;
   assign trade_count = trade_count_q;
   assign timeout     = timeout_q;
   assign err         = err_q;

endmodule
